serial_xor_arbiter: RTL and testbench

SERIAL_XOR_ARBITER -- requirements
Module: serial_xor_arbiter

---
 rtl/serial_xor_arbiter_pkg.sv | 10 +
 rtl/serial_xor_arbiter_xor.sv | 10 +
 rtl/serial_xor_arbiter.sv | 135 +++++++++++++
 tb/tb_serial_xor_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_xor_arbiter_pkg.sv
// Shared definitions for the serial XOR arbiter: FSM state encoding.
package serial_xor_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_xor_arbiter_xor.sv
// Single-bit XOR gate cell; the only XOR used to build the arbiter result.
module serial_xor_arbiter_xor (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = a ^ b;

endmodule

// File: rtl/serial_xor_arbiter.sv
// Two-requester round-robin arbiter feeding a bit-serial XOR datapath.
// The winner's operands are captured in IDLE, shifted LSB first through one
// shared XOR cell in SHIFT, and the result is published for one cycle in DONE.
module serial_xor_arbiter
  import serial_xor_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] y
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             id_q, id_d;
  // Last requester served; doubles as the id of the operation in flight.
  logic             rr_q, rr_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;

  logic             win;
  logic             xor_bit;
  logic [WIDTH:0]   res_cat;
  logic [WIDTH-1:0] res_shift;

  serial_xor_arbiter_xor u_xor (
    .a (opa_q[0]),
    .b (opb_q[0]),
    .y (xor_bit)
  );

  // Result enters at the MSB so bit 0 lands at position 0 after WIDTH shifts.
  assign res_cat   = {xor_bit, res_q};
  assign res_shift = res_cat[WIDTH:1];

  // Winner: the lone requester, or the one not served last when both ask.
  assign win = (req0 && req1) ? ~rr_q : req1;

  // Next-state logic for arbitration, operand capture and serial shifting.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    y_d     = y_q;
    id_d    = id_q;
    rr_d    = rr_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          opa_d   = win ? a1 : a0;
          opb_d   = win ? b1 : b0;
          cnt_d   = '0;
          rr_d    = win;
          gnt0_d  = ~win;
          gnt1_d  = win;
          state_d = StShift;
        end
      end
      StShift: begin
        opa_d = opa_q >> 1;
        opb_d = opb_q >> 1;
        res_d = res_shift;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          y_d     = res_shift;
          id_d    = rr_q;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers; reset points the round-robin at requester 1 so 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      y_q     <= '0;
      id_q    <= 1'b0;
      rr_q    <= 1'b1;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      y_q     <= y_d;
      id_q    <= id_d;
      rr_q    <= rr_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
    end
  end

  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign busy    = (state_q != StIdle);
  assign done    = (state_q == StDone);
  assign done_id = id_q;
  assign y       = y_q;

endmodule

// File: tb/tb_serial_xor_arbiter.sv
// Scoreboard bench for serial_xor_arbiter: drivers push expected results,
// a negedge monitor pops and compares whenever done is seen.
module tb_serial_xor_arbiter;

  localparam int W   = 8;
  localparam int TMO = 4 * W + 20;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic         gnt0, gnt1, busy, done, done_id;
  logic [W-1:0] y;

  // Second build with WIDTH=1 for the degenerate case.
  logic w1_req0 = 1'b0, w1_a0 = 1'b0, w1_b0 = 1'b0;
  logic w1_zero = 1'b0;
  logic w1_gnt0, w1_gnt1, w1_busy, w1_done, w1_done_id, w1_y;

  serial_xor_arbiter #(.WIDTH(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done), .done_id(done_id), .y(y)
  );

  serial_xor_arbiter #(.WIDTH(1)) u_dut_w1 (
    .clk(clk), .rst_n(rst_n), .req0(w1_req0), .req1(w1_zero),
    .a0(w1_a0), .b0(w1_b0), .a1(w1_zero), .b1(w1_zero),
    .gnt0(w1_gnt0), .gnt1(w1_gnt1), .busy(w1_busy), .done(w1_done),
    .done_id(w1_done_id), .y(w1_y)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           id;
    logic [W-1:0] y;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  int           n_chk = 0;
  int           n_pass = 0;
  int           cyc = 0;
  bit           last = 1'b1;
  logic [W-1:0] hold_y = '0;
  bit           hold_id = 1'b0;
  bit           prev_gnt = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: score every done, and check y/done_id hold between dones.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        if (sb.size() == 0) begin
          check("done_unexpected", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          check("y", y, mon_e.y);
          check("done_id", done_id, mon_e.id);
          check("done_cycle", cyc, mon_e.cyc);
          hold_y  = mon_e.y;
          hold_id = mon_e.id;
        end
      end else begin
        check("y_hold", y, hold_y);
        check("id_hold", done_id, hold_id);
      end
      if (gnt0 || gnt1) begin
        check("gnt_pulse", prev_gnt, 0);
        check("gnt_exclusive", gnt0 && gnt1, 0);
      end
      prev_gnt = gnt0 || gnt1;
    end else begin
      prev_gnt = 1'b0;
    end
  end

  task automatic wait_gnt(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < TMO && !ok; i++) begin
      @(negedge clk);
      if (gnt0 || gnt1) ok = 1'b1;
    end
    if (!ok) check("grant_timeout", 0, 1);
  endtask

  // Apply one request pattern; each grant is checked against the round-robin
  // model and its expected result is queued. Winner's operands are scrambled
  // after capture to show the operation in flight is unaffected.
  task automatic issue(input bit r0, input bit r1, input logic [W-1:0] x0, input logic [W-1:0] z0,
                       input logic [W-1:0] x1, input logic [W-1:0] z1);
    bit ok;
    bit win;
    exp_t e;
    req0 = r0; req1 = r1; a0 = x0; b0 = z0; a1 = x1; b1 = z1;
    while (req0 || req1) begin
      wait_gnt(ok);
      if (!ok) begin
        req0 = 1'b0; req1 = 1'b0;
        break;
      end
      win = (req0 && req1) ? !last : req1;
      check("gnt_winner", {gnt1, gnt0}, win ? 2'b10 : 2'b01);
      last  = win;
      e.id  = win;
      e.y   = win ? (a1 ^ b1) : (a0 ^ b0);
      e.cyc = cyc + W;
      sb.push_back(e);
      if (win) begin
        req1 = 1'b0; a1 = W'($urandom); b1 = W'($urandom);
      end else begin
        req0 = 1'b0; a0 = W'($urandom); b0 = W'($urandom);
      end
    end
  endtask

  // Both requests held across four operations: alternation and W+2 spacing.
  task automatic held4();
    bit ok;
    bit win;
    int prev;
    exp_t e;
    prev = 0;
    req0 = 1'b1; req1 = 1'b1;
    a0 = W'($urandom); b0 = W'($urandom); a1 = W'($urandom); b1 = W'($urandom);
    for (int k = 0; k < 4; k++) begin
      wait_gnt(ok);
      if (!ok) break;
      win = !last;
      check("held_winner", {gnt1, gnt0}, win ? 2'b10 : 2'b01);
      if (k > 0) check("gnt_spacing", cyc - prev, W + 2);
      prev  = cyc;
      last  = win;
      e.id  = win;
      e.y   = win ? (a1 ^ b1) : (a0 ^ b0);
      e.cyc = cyc + W;
      sb.push_back(e);
      if (win) begin
        a1 = W'($urandom); b1 = W'($urandom);
      end else begin
        a0 = W'($urandom); b0 = W'($urandom);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < TMO && sb.size() != 0; i++) @(negedge clk);
    check("drain", sb.size(), 0);
  endtask

  // Hold reset with requests toggling; all outputs must stay at zero.
  task automatic do_reset();
    rst_n = 1'b0;
    sb.delete();
    last = 1'b1; hold_y = '0; hold_id = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req0 = i[0]; req1 = !i[0];
      a0 = W'($urandom); b0 = W'($urandom);
      @(negedge clk);
      check("rst_gnt", {gnt1, gnt0}, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_y", y, 0);
      check("rst_done_id", done_id, 0);
    end
    req0 = 1'b0; req1 = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    bit ok;
    int c0;
    bit r0, r1;
    int pat;
    logic [1:0] ab;
    @(negedge clk);
    do_reset();

    // Simultaneous requests right after reset: requester 0 first.
    issue(1, 1, 8'hFF, 8'h00, 8'h3C, 8'h3C);
    drain();
    // Single request.
    issue(1, 0, 8'hA5, 8'h0F, 8'h00, 8'h00);
    drain();

    do_reset();
    held4();
    drain();

    for (int n = 0; n < 24; n++) begin
      pat = $urandom_range(0, 2);
      r0  = (pat != 1);
      r1  = (pat != 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(r0, r1, W'($urandom), W'($urandom), W'($urandom), W'($urandom));
    end
    drain();

    // Reset after the 4th shift edge abandons the operation.
    issue(1, 0, W'($urandom), W'($urandom), 8'h00, 8'h00);
    repeat (4) @(negedge clk);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_done", done, 0);
      check("post_rst_busy", busy, 0);
    end
    issue(0, 1, 8'h00, 8'h00, 8'h12, 8'h34);
    drain();

    // WIDTH=1 build: done one edge after capture, y = a ^ b.
    for (int i = 0; i < 4; i++) begin
      ab = i[1:0];
      w1_a0 = ab[0]; w1_b0 = ab[1]; w1_req0 = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 10 && !ok; t++) begin
        @(negedge clk);
        if (w1_gnt0) ok = 1'b1;
      end
      check("w1_gnt", ok, 1);
      c0 = cyc;
      w1_req0 = 1'b0; w1_a0 = !ab[0];
      @(negedge clk);
      check("w1_done", w1_done, 1);
      check("w1_latency", cyc - c0, 1);
      check("w1_y", w1_y, ab[0] ^ ab[1]);
      check("w1_done_id", w1_done_id, 0);
      @(negedge clk);
      check("w1_done_pulse", w1_done, 0);
    end

    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
